// File: rtl/clk_switch_ctrl_if.sv
// Port bundle between the clock-switch selection controller and its user:
// the toggle inputs, the software select handshake and the switch controls.
interface clk_switch_ctrl_if #(
    parameter int CLK_NUM = 4
);
    localparam int SelW = $clog2(CLK_NUM);

    logic [CLK_NUM-1:0] clk_tgl;
    logic               auto_en;
    logic [SelW-1:0]    sw_sel;
    logic               sw_sel_vld;
    logic               sw_sel_rdy;
    logic [SelW-1:0]    sel;
    logic [CLK_NUM-1:0] clk_fail;
    logic               all_fail;
    logic               switch_busy;
    logic               fail_irq;

    // Requester / environment side: drives toggles and software requests.
    modport master (
        output clk_tgl, auto_en, sw_sel, sw_sel_vld,
        input  sw_sel_rdy, sel, clk_fail, all_fail, switch_busy, fail_irq
    );

    // Controller side.
    modport slave (
        input  clk_tgl, auto_en, sw_sel, sw_sel_vld,
        output sw_sel_rdy, sel, clk_fail, all_fail, switch_busy, fail_irq
    );
endinterface

// File: rtl/clk_switch_ctrl.sv
// Selection controller for the glitch-free clock switch. Monitors each source
// through its divide-by-2 toggle, flags dead sources with two-window recovery
// hysteresis, and drives the switch select from software requests or from
// automatic failover, holding every new select for a settle period.
module clk_switch_ctrl #(
    parameter int CLK_NUM     = 4,
    parameter int WIN_CYC     = 64,
    parameter int MIN_EDGES   = 4,
    parameter int SETTLE_CYC  = 16,
    parameter int DEFAULT_SEL = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    clk_switch_ctrl_if.slave  bus
);
    localparam int SelW     = $clog2(CLK_NUM);
    localparam int SelRange = 1 << SelW;
    localparam int WinW     = $clog2(WIN_CYC);
    localparam int EdgeW    = $clog2(MIN_EDGES + 1);
    localparam int SettleW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    logic [CLK_NUM-1:0]            tglMeta_q, tglSync_q, tglHist_q;
    logic [CLK_NUM-1:0]            tglEdge;
    logic [WinW-1:0]               winCnt_q, winCnt_d;
    logic                          winEnd;
    logic [CLK_NUM-1:0][EdgeW-1:0] edgeCnt_q, edgeCnt_d;
    logic [CLK_NUM-1:0]            fail_q, fail_d;
    logic [CLK_NUM-1:0]            streak_q, streak_d;
    logic [CLK_NUM-1:0]            healthy;
    logic                          allFail_q, allFail_d;

    state_t                        state_q, state_d;
    logic [SelW-1:0]               sel_q, sel_d;
    logic [SettleW-1:0]            settleCnt_q, settleCnt_d;
    logic                          irq_q, irq_d;
    logic                          rdy;
    logic                          failover;
    logic [SelRange-1:0]           failPad;
    logic [SelRange-1:0]           validIdx;
    logic [SelW-1:0]               firstGood;

    // Two-flop synchronizer per toggle plus a history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tglMeta_q <= '0;
            tglSync_q <= '0;
            tglHist_q <= '0;
        end else begin
            tglMeta_q <= bus.clk_tgl;
            tglSync_q <= tglMeta_q;
            tglHist_q <= tglSync_q;
        end
    end

    assign tglEdge = tglSync_q ^ tglHist_q;
    assign winEnd  = (winCnt_q == WinW'(WIN_CYC - 1));
    assign winCnt_d = winEnd ? '0 : winCnt_q + 1'b1;

    // Per-source edge counting and window-end health evaluation; an edge on
    // the closing cycle still belongs to the closing window.
    always_comb begin
        edgeCnt_d = edgeCnt_q;
        fail_d    = fail_q;
        streak_d  = streak_q;
        healthy   = '0;
        for (int i = 0; i < CLK_NUM; i++) begin
            healthy[i] = (({1'b0, edgeCnt_q[i]} + {{EdgeW{1'b0}}, tglEdge[i]})
                          >= (EdgeW + 1)'(MIN_EDGES));
            if (winEnd) begin
                edgeCnt_d[i] = '0;
                if (!healthy[i]) begin
                    fail_d[i]   = 1'b1;
                    streak_d[i] = 1'b0;
                end else if (fail_q[i]) begin
                    if (streak_q[i]) begin
                        fail_d[i]   = 1'b0;
                        streak_d[i] = 1'b0;
                    end else begin
                        streak_d[i] = 1'b1;
                    end
                end else begin
                    streak_d[i] = 1'b0;
                end
            end else if (tglEdge[i] && (edgeCnt_q[i] != EdgeW'(MIN_EDGES))) begin
                edgeCnt_d[i] = edgeCnt_q[i] + 1'b1;
            end
        end
        allFail_d = &fail_d;
    end

    // Monitor state: window position, edge counts, fail flags and streaks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winCnt_q  <= '0;
            edgeCnt_q <= '0;
            fail_q    <= '0;
            streak_q  <= '0;
            allFail_q <= 1'b0;
        end else begin
            winCnt_q  <= winCnt_d;
            edgeCnt_q <= edgeCnt_d;
            fail_q    <= fail_d;
            streak_q  <= streak_d;
            allFail_q <= allFail_d;
        end
    end

    // Helper vectors: fail flags widened to the select range, legal indices,
    // and the lowest-index source that is still healthy.
    always_comb begin
        failPad                = '0;
        failPad[CLK_NUM-1:0]   = fail_q;
        validIdx               = '0;
        for (int k = 0; k < SelRange; k++) begin
            validIdx[k] = (k < CLK_NUM);
        end
        firstGood = '0;
        for (int k = CLK_NUM - 1; k >= 0; k--) begin
            if (!fail_q[k]) begin
                firstGood = SelW'(k);
            end
        end
    end

    assign failover = (state_q == IDLE) && bus.auto_en && failPad[sel_q] && !allFail_q;

    // Select FSM: failover beats software requests; any select change enters
    // SETTLE so the switch handover finishes before the next change.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        settleCnt_d = settleCnt_q;
        irq_d       = 1'b0;
        rdy         = 1'b0;
        case (state_q)
            IDLE: begin
                if (failover) begin
                    sel_d       = firstGood;
                    irq_d       = 1'b1;
                    state_d     = SETTLE;
                    settleCnt_d = SettleW'(SETTLE_CYC - 1);
                end else begin
                    rdy = 1'b1;
                    if (bus.sw_sel_vld && validIdx[bus.sw_sel] && (bus.sw_sel != sel_q)) begin
                        sel_d       = bus.sw_sel;
                        state_d     = SETTLE;
                        settleCnt_d = SettleW'(SETTLE_CYC - 1);
                    end
                end
            end
            SETTLE: begin
                if (settleCnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    settleCnt_d = settleCnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Select FSM registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= SelW'(DEFAULT_SEL);
            settleCnt_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            settleCnt_q <= settleCnt_d;
            irq_q       <= irq_d;
        end
    end

    assign bus.sw_sel_rdy  = rdy;
    assign bus.sel         = sel_q;
    assign bus.clk_fail    = fail_q;
    assign bus.all_fail    = allFail_q;
    assign bus.switch_busy = (state_q == SETTLE);
    assign bus.fail_irq    = irq_q;
endmodule
